// File: rtl/sim_uart_rx_sink_pkg.sv
// Shared types and constants for the simulation UART receive sink.
// The PAR state exists only when SIM_UART_RX_PARITY_EN is defined.
package sonata_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
`ifdef SIM_UART_RX_PARITY_EN
      ST_PAR,
`endif
      ST_STOP
   } rx_state_e;

   localparam logic [7:0] NEWLINE = 8'h0A;

endpackage

// File: rtl/sim_uart_rx_sink_if.sv
// Received-byte stream handshake: the sink is master, the consumer is slave.
interface sim_uart_rx_sink_if;
   logic [7:0] rx_data_o;
   logic       rx_valid_o;
   logic       rx_ready_i;

   modport master (output rx_data_o, output rx_valid_o, input rx_ready_i);
   modport slave  (input rx_data_o, input rx_valid_o, output rx_ready_i);
endinterface

// File: rtl/sim_uart_rx_fifo.sv
// Received-byte FIFO with wrap-bit pointers; a full FIFO still accepts a push when popped in the same cycle.
module sim_uart_rx_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic             empty_o,
   output logic             full_o,
   output logic             accept_o
);

   localparam int AW = $clog2(DEPTH);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("sim_uart_rx_fifo: DEPTH must be a power of two >= 2");
   end

   logic [AW:0]      wr_ptr_q;
   logic [AW:0]      rd_ptr_q;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             rd_en;

   assign empty_o  = (wr_ptr_q == rd_ptr_q);
   assign full_o   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign accept_o = push_i && (!full_o || pop_i);
   assign rd_en    = pop_i && !empty_o;
   // Head reads as zero when empty so the output is defined straight out of reset.
   assign data_o   = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (accept_o) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (rd_en)    rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (accept_o) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
   end

endmodule

// File: rtl/sim_uart_rx_sink.sv
// UART receive sink: 8N1 deserializer feeding a byte FIFO, with frame/overflow/newline flags.
// Define SIM_UART_RX_PARITY_EN for 8E1 frames and the parity_err_o output.
//
// state   | meaning
// IDLE    | line idle, waiting for a synchronized falling edge
// START   | counting to mid start bit; high there means glitch
// DATA    | sampling 8 data bits, LSB first, one per bit period
// PAR     | sampling the even-parity bit (parity builds only)
// STOP    | sampling the stop bit; after a bad stop, waits for line high
module sim_uart_rx_sink
   import sonata_pkg::*;
#(
   parameter int FREQ       = 30_000_000,
   parameter int BAUD       = 921_600,
   parameter int FIFO_DEPTH = 8
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               rx_i,
   sim_uart_rx_sink_if.master rx_if,
   output logic               frame_err_o,
   output logic               overflow_o,
`ifdef SIM_UART_RX_PARITY_EN
   output logic               parity_err_o,
`endif
   output logic               line_o
);

   localparam int CLKS_PER_BIT = FREQ / BAUD;
   localparam int CNT_W        = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);

   if (CLKS_PER_BIT < 4) begin : g_bad_baud
      $error("sim_uart_rx_sink: FREQ/BAUD must be at least 4");
   end

   logic [1:0]       sync_q;
   logic             rx_s;
   logic             rx_prev_q;
   rx_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       shift_q, shift_d;
   logic             stop_wait_q, stop_wait_d;
   logic             push, frame_err, par_ok;
   logic             overflow_q;
   logic             fifo_empty, fifo_full, fifo_wr, pop;

`ifdef SIM_UART_RX_PARITY_EN
   logic par_bad_q, par_bad_d, parity_err;
   assign par_ok       = !par_bad_q;
   assign parity_err_o = parity_err;
`else
   assign par_ok = 1'b1;
`endif

   assign rx_s = sync_q[1];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q    <= 2'b11;
         rx_prev_q <= 1'b1;
      end else begin
         sync_q    <= {sync_q[0], rx_i};
         rx_prev_q <= rx_s;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         bit_q       <= '0;
         shift_q     <= '0;
         stop_wait_q <= 1'b0;
`ifdef SIM_UART_RX_PARITY_EN
         par_bad_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bit_q       <= bit_d;
         shift_q     <= shift_d;
         stop_wait_q <= stop_wait_d;
`ifdef SIM_UART_RX_PARITY_EN
         par_bad_q   <= par_bad_d;
`endif
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q - 1'b1;
      bit_d       = bit_q;
      shift_d     = shift_q;
      stop_wait_d = stop_wait_q;
      push        = 1'b0;
      frame_err   = 1'b0;
`ifdef SIM_UART_RX_PARITY_EN
      par_bad_d   = par_bad_q;
      parity_err  = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (rx_prev_q && !rx_s) begin
               state_d = ST_START;
               cnt_d   = CNT_HALF;
            end
         end
         ST_START: begin
            if (cnt_q == '0) begin
               if (!rx_s) begin
                  state_d = ST_DATA;
                  cnt_d   = CNT_FULL;
                  bit_d   = '0;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         ST_DATA: begin
            if (cnt_q == '0) begin
               shift_d = {rx_s, shift_q[7:1]};
               cnt_d   = CNT_FULL;
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) begin
`ifdef SIM_UART_RX_PARITY_EN
                  state_d = ST_PAR;
`else
                  state_d = ST_STOP;
`endif
               end
            end
         end
`ifdef SIM_UART_RX_PARITY_EN
         ST_PAR: begin
            if (cnt_q == '0) begin
               par_bad_d  = ^{shift_q, rx_s};
               parity_err = par_bad_d;
               cnt_d      = CNT_FULL;
               state_d    = ST_STOP;
            end
         end
`endif
         ST_STOP: begin
            if (stop_wait_q) begin
               if (rx_s) begin
                  stop_wait_d = 1'b0;
                  state_d     = ST_IDLE;
               end
            end else if (cnt_q == '0) begin
               if (rx_s) begin
                  push    = par_ok;
                  state_d = ST_IDLE;
               end else begin
                  frame_err   = 1'b1;
                  stop_wait_d = 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // Pulses stay quiet in a reset cycle even if the old state would raise them.
      if (rst_i) begin
         push      = 1'b0;
         frame_err = 1'b0;
`ifdef SIM_UART_RX_PARITY_EN
         parity_err = 1'b0;
`endif
      end
   end

   assign pop              = rx_if.rx_valid_o && rx_if.rx_ready_i;
   assign rx_if.rx_valid_o = !fifo_empty;

   sim_uart_rx_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .push_i   (push),
      .data_i   (shift_q),
      .pop_i    (pop),
      .data_o   (rx_if.rx_data_o),
      .empty_o  (fifo_empty),
      .full_o   (fifo_full),
      .accept_o (fifo_wr)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i)                 overflow_q <= 1'b0;
      else if (push && !fifo_wr) overflow_q <= 1'b1;
   end

   assign overflow_o  = overflow_q;
   assign frame_err_o = frame_err;
   assign line_o      = fifo_wr && (shift_q == NEWLINE);

endmodule

// File: tb/tb_sim_uart_rx_sink.sv
// Directed bench for sim_uart_rx_sink at default parameters (32 clocks per bit, 8N1).
module tb_sim_uart_rx_sink;

   localparam int CPB = 32;

   logic clk = 1'b0;
   logic rst;
   logic rx;
   logic frame_err, overflow, line;
`ifdef SIM_UART_RX_PARITY_EN
   logic parity_err;
`endif

   always #5 clk = ~clk;

   sim_uart_rx_sink_if u_if ();

   sim_uart_rx_sink dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .rx_i         (rx),
      .rx_if        (u_if.master),
      .frame_err_o  (frame_err),
      .overflow_o   (overflow),
`ifdef SIM_UART_RX_PARITY_EN
      .parity_err_o (parity_err),
`endif
      .line_o       (line)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int cyc, first_valid, pop_at, fe_cnt, ln_cnt;
   int fe0, ln0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // One clock: ready driven just after the edge, outputs sampled a little later.
   task automatic tick();
      @(posedge clk);
      cyc++;
      #1 u_if.rx_ready_i = (cyc == pop_at);
      #1;
      if (frame_err === 1'b1) fe_cnt++;
      if (line === 1'b1) ln_cnt++;
      if (u_if.rx_valid_o === 1'b1 && first_valid < 0) first_valid = cyc;
   endtask

   task automatic drive(input logic val, input int n);
      rx = val;
      repeat (n) tick();
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop);
      cyc = 0;
      first_valid = -1;
      drive(1'b0, CPB);
      for (int i = 0; i < 8; i++) drive(b[i], CPB);
      drive(stop, CPB);
   endtask

   task automatic pop_expect(input string tag, input logic [7:0] exp);
      check({tag, "_valid"}, 32'(u_if.rx_valid_o), 32'd1);
      check({tag, "_data"}, 32'(u_if.rx_data_o), 32'(exp));
      u_if.rx_ready_i = 1'b1;
      @(posedge clk);
      #1 u_if.rx_ready_i = 1'b0;
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      repeat (2) tick();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: bench did not finish, got timeout expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] b7e;
      rst = 1'b1;
      rx  = 1'b1;
      u_if.rx_ready_i = 1'b0;
      pop_at = -1;
      cyc = 0;
      first_valid = -1;
      fe_cnt = 0;
      ln_cnt = 0;
      repeat (4) tick();
      check("rst_valid", 32'(u_if.rx_valid_o), 32'd0);
      check("rst_data", 32'(u_if.rx_data_o), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      check("rst_frame_err", 32'(frame_err), 32'd0);
      check("rst_line", 32'(line), 32'd0);
      rst = 1'b0;
      repeat (5) tick();

      // 0x55: valid first seen 308 cycles after the start edge (2 sync + 1 edge + 16 half + 9*32 + 1 push).
      fe0 = fe_cnt; ln0 = ln_cnt;
      send_frame(8'h55, 1'b1);
      check("lat_0x55", 32'(first_valid), 32'd308);
      check("ferr_0x55", 32'(fe_cnt - fe0), 32'd0);
      check("line_0x55", 32'(ln_cnt - ln0), 32'd0);
      pop_expect("b55", 8'h55);
      check("empty_after_55", 32'(u_if.rx_valid_o), 32'd0);

      // short low glitch on an idle line
      fe0 = fe_cnt;
      drive(1'b0, 10);
      drive(1'b1, 80);
      check("glitch_valid", 32'(u_if.rx_valid_o), 32'd0);
      check("glitch_ferr", 32'(fe_cnt - fe0), 32'd0);

      // bad stop bit
      fe0 = fe_cnt;
      send_frame(8'hA3, 1'b0);
      drive(1'b1, 40);
      check("stop_ferr_cnt", 32'(fe_cnt - fe0), 32'd1);
      check("stop_valid", 32'(u_if.rx_valid_o), 32'd0);

      // nine bytes into an eight-entry FIFO with no consumer
      ln0 = ln_cnt;
      for (int i = 0; i < 9; i++) send_frame(8'(i), 1'b1);
      drive(1'b1, 10);
      check("ovf_flag", 32'(overflow), 32'd1);
      check("ovf_line", 32'(ln_cnt - ln0), 32'd0);
      for (int i = 0; i < 8; i++) pop_expect($sformatf("ovf_pop%0d", i), 8'(i));
      check("ovf_empty", 32'(u_if.rx_valid_o), 32'd0);

      // full FIFO, pop coincides with push of newline
      do_reset();
      check("ovf_cleared", 32'(overflow), 32'd0);
      for (int i = 0; i < 8; i++) send_frame(8'(8'h10 + i), 1'b1);
      drive(1'b1, 10);
      check("full_ovf", 32'(overflow), 32'd0);
      ln0 = ln_cnt;
      pop_at = 307;
      send_frame(8'h0A, 1'b1);
      pop_at = -1;
      drive(1'b1, 10);
      check("nl_line_cnt", 32'(ln_cnt - ln0), 32'd1);
      check("nl_ovf", 32'(overflow), 32'd0);
      for (int i = 1; i < 8; i++) pop_expect($sformatf("nl_pop%0d", i), 8'(8'h10 + i));
      pop_expect("nl_pop_0a", 8'h0A);
      check("nl_empty", 32'(u_if.rx_valid_o), 32'd0);

      // reset during data bit 4 of 0x7E, held until the frame has passed
      b7e = 8'h7E;
      fe0 = fe_cnt;
      cyc = 0;
      drive(1'b0, CPB);
      for (int i = 0; i < 4; i++) drive(b7e[i], CPB);
      drive(b7e[4], 10);
      rst = 1'b1;
      drive(b7e[4], CPB - 10);
      for (int i = 5; i < 8; i++) drive(b7e[i], CPB);
      drive(1'b1, CPB);
      rst = 1'b0;
      drive(1'b1, 20);
      check("rstmid_valid", 32'(u_if.rx_valid_o), 32'd0);
      check("rstmid_ferr", 32'(fe_cnt - fe0), 32'd0);
      send_frame(8'h31, 1'b1);
      drive(1'b1, 5);
      pop_expect("b31", 8'h31);
      check("b31_empty", 32'(u_if.rx_valid_o), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
